// File: rtl/restoring_divider.sv
// rtl/restoring_divider.sv - N-bit unsigned restoring divider, one quotient bit per cycle
// Optional feature macro: DIVZERO_DETECT_EN (zero divisor short-circuits straight to DONE with dz=1)
module restoring_divider #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         busy,
    output logic         done,
    output logic         dz
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_ITER = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [N:0]    a_reg;
    logic [N-1:0]  q_reg;
    logic [N-1:0]  m_reg;
    logic [CW-1:0] c_reg;
    logic [N-1:0]  quotient_reg;
    logic [N-1:0]  remainder_reg;
    logic          dz_reg;

    logic [N:0]    a_sh;
    logic [N:0]    t_diff;
    logic [N:0]    a_nxt;
    logic [N-1:0]  q_nxt;
    logic          last_iter;
    logic          zero_div;

`ifdef DIVZERO_DETECT_EN
    assign zero_div = (divisor == '0);
`else
    assign zero_div = 1'b0;
`endif

    // One restoring step: shift {A,Q} left, trial-subtract M, restore on borrow
    always_comb begin
        a_sh   = {a_reg[N-1:0], q_reg[N-1]};
        t_diff = a_sh - {1'b0, m_reg};
        a_nxt  = t_diff[N] ? a_sh : t_diff;
        q_nxt  = {q_reg[N-2:0], ~t_diff[N]};
    end

    // C counts down from N; the step taken while C==1 is the last of N
    assign last_iter = (c_reg == CW'(1));

    // State register; reset drops straight to IDLE without a clock edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start is only looked at in IDLE so nothing is queued
    always_comb begin
        state_nxt = S_IDLE;
        case (state)
            S_IDLE: state_nxt = start ? S_LOAD : S_IDLE;
            S_LOAD: state_nxt = zero_div ? S_DONE : S_ITER;
            S_ITER: state_nxt = last_iter ? S_DONE : S_ITER;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath and result registers; results change only on the edge entering DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg         <= '0;
            q_reg         <= '0;
            m_reg         <= '0;
            c_reg         <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dz_reg        <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    a_reg <= '0;
                    q_reg <= dividend;
                    m_reg <= divisor;
                    c_reg <= CW'(N);
                    if (zero_div) begin
                        quotient_reg  <= '1;
                        remainder_reg <= dividend;
                        dz_reg        <= 1'b1;
                    end
                end
                S_ITER: begin
                    a_reg <= a_nxt;
                    q_reg <= q_nxt;
                    c_reg <= c_reg - CW'(1);
                    if (last_iter) begin
                        quotient_reg  <= q_nxt;
                        remainder_reg <= a_nxt[N-1:0];
                        dz_reg        <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign quotient  = quotient_reg;
    assign remainder = remainder_reg;
    assign dz        = dz_reg;
    assign busy      = (state == S_LOAD) || (state == S_ITER);
    assign done      = (state == S_DONE);

endmodule

// File: tb/tb_restoring_divider.sv
// tb/tb_restoring_divider.sv - self-checking bench for restoring_divider (N=8)
module tb_restoring_divider;

    localparam int N = 8;
`ifdef DIVZERO_DETECT_EN
    localparam bit DZ_EN = 1'b1;
`else
    localparam bit DZ_EN = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         busy;
    logic         done;
    logic         dz;

    int checks;
    int failures;

    restoring_divider #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .dz        (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer division, with the zero-divisor convention
    function automatic void model(input int a, input int b, output int q, output int r,
                                  output int z, output int lat);
        if (b == 0) begin
            q   = 255;
            r   = a;
            z   = DZ_EN ? 1 : 0;
            lat = DZ_EN ? 2 : N + 2;
        end else begin
            q   = a / b;
            r   = a % b;
            z   = 0;
            lat = N + 2;
        end
    endfunction

    // Runs one division and reports what it saw (edges until done, results, single-cycle pulse)
    task automatic do_div(input int a, input int b, output int lat, output int q, output int r,
                          output int z, output int pulse_ok);
        @(negedge clk);
        dividend = a[N-1:0];
        divisor  = b[N-1:0];
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        q = quotient;
        r = remainder;
        z = dz;
        @(posedge clk);
        #1;
        pulse_ok = (done == 1'b0) ? 1 : 0;
    endtask

    task automatic check_div(input string name, input int a, input int b);
        int lat, q, r, z, p;
        int eq, er, ez, el;
        model(a, b, eq, er, ez, el);
        do_div(a, b, lat, q, r, z, p);
        checks++;
        if (lat !== el) begin
            failures++;
            $display("FAIL %s latency %0d/%0d: got %0d expected %0d", name, a, b, lat, el);
        end
        checks++;
        if (q !== eq) begin
            failures++;
            $display("FAIL %s quotient %0d/%0d: got %0d expected %0d", name, a, b, q, eq);
        end
        checks++;
        if (r !== er) begin
            failures++;
            $display("FAIL %s remainder %0d/%0d: got %0d expected %0d", name, a, b, r, er);
        end
        checks++;
        if (z !== ez) begin
            failures++;
            $display("FAIL %s dz %0d/%0d: got %0d expected %0d", name, a, b, z, ez);
        end
        checks++;
        if (p !== 1) begin
            failures++;
            $display("FAIL %s done_width %0d/%0d: done still high the cycle after", name, a, b);
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #12;
        checks++;
        if ({quotient, remainder, busy, done, dz} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got q=%0d r=%0d busy=%0b done=%0b dz=%0b expected all 0",
                     quotient, remainder, busy, done, dz);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done} !== 2'b00) begin
            failures++;
            $display("FAIL reset_idle: got busy=%0b done=%0b expected 0 0", busy, done);
        end
    endtask

    task automatic test_directed();
        check_div("div_100_7", 100, 7);
        check_div("div_5_9", 5, 9);
        check_div("div_255_1", 255, 1);
        check_div("div_200_0", 200, 0);
        check_div("div_0_3", 0, 3);
        check_div("div_255_255", 255, 255);
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            int a, b;
            a = $urandom_range(0, 255);
            b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
            check_div("random", a, b);
        end
    endtask

    task automatic test_busy();
        @(negedge clk);
        dividend = 8'd77;
        divisor  = 8'd6;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_in_load: got %0b expected 1", busy);
        end
        repeat (9) @(posedge clk);
        #1;
        checks++;
        if ({busy, done} !== 2'b01) begin
            failures++;
            $display("FAIL busy_at_done: got busy=%0b done=%0b expected 0 1", busy, done);
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic test_back_to_back();
        int hits[$];
        @(negedge clk);
        dividend = 8'd255;
        divisor  = 8'd1;
        start    = 1'b1;
        for (int e = 1; e <= 35; e++) begin
            @(posedge clk);
            #1;
            if (done) begin
                hits.push_back(e);
                checks++;
                if (quotient !== 8'd255 || remainder !== 8'd0) begin
                    failures++;
                    $display("FAIL b2b_result: got %0d r %0d expected 255 r 0", quotient, remainder);
                end
            end
        end
        start = 1'b0;
        checks++;
        if (hits.size() !== 3) begin
            failures++;
            $display("FAIL b2b_count: got %0d done pulses expected 3", hits.size());
        end else begin
            checks++;
            if (hits[0] !== N + 2) begin
                failures++;
                $display("FAIL b2b_first: got edge %0d expected %0d", hits[0], N + 2);
            end
            for (int k = 1; k < 3; k++) begin
                checks++;
                if (hits[k] - hits[k-1] !== N + 3) begin
                    failures++;
                    $display("FAIL b2b_period: got %0d expected %0d", hits[k] - hits[k-1], N + 3);
                end
            end
        end
        repeat (12) @(posedge clk);
    endtask

    task automatic test_ignore_start();
        int pulses;
        int q, r;
        pulses = 0;
        q      = -1;
        r      = -1;
        @(negedge clk);
        dividend = 8'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        start    = 1'b1;
        dividend = 8'd50;
        divisor  = 8'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int e = 0; e < 30; e++) begin
            dividend = $urandom_range(0, 255);
            divisor  = $urandom_range(0, 255);
            @(posedge clk);
            #1;
            if (done) begin
                pulses++;
                if (pulses == 1) begin
                    q = quotient;
                    r = remainder;
                end
            end
        end
        checks++;
        if (pulses !== 1) begin
            failures++;
            $display("FAIL ignore_pulses: got %0d expected 1", pulses);
        end
        checks++;
        if (q !== 14 || r !== 2) begin
            failures++;
            $display("FAIL ignore_result: got %0d r %0d expected 14 r 2", q, r);
        end
    endtask

    task automatic test_mid_reset();
        int pulses;
        int lat, q, r, z, p;
        pulses = 0;
        @(negedge clk);
        dividend = 8'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({quotient, remainder, busy, done, dz} !== '0) begin
            failures++;
            $display("FAIL midreset_outputs: got q=%0d r=%0d busy=%0b done=%0b dz=%0b expected all 0",
                     quotient, remainder, busy, done, dz);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int e = 0; e < 15; e++) begin
            @(posedge clk);
            #1;
            if (done || busy) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            failures++;
            $display("FAIL midreset_nodone: got %0d active cycles expected 0", pulses);
        end
        do_div(9, 3, lat, q, r, z, p);
        checks++;
        if (q !== 3 || r !== 0 || lat !== N + 2) begin
            failures++;
            $display("FAIL midreset_fresh: got %0d r %0d lat %0d expected 3 r 0 lat %0d", q, r, lat, N + 2);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_directed();
        test_random();
        test_busy();
        test_back_to_back();
        test_ignore_start();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/restoring_divider.md
RESTORING_DIVIDER -- requirements
Module: restoring_divider

Interface
REQ-001 SHALL provide parameter N, default 8, giving the operand, quotient and remainder width in bits (N >= 2).
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL provide port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide port start  input  1  request a division; sampled only in IDLE.
REQ-005 SHALL provide port dividend  input  N  unsigned dividend; captured in LOAD.
REQ-006 SHALL provide port divisor  input  N  unsigned divisor; captured in LOAD.
REQ-007 SHALL provide port quotient  output  N  registered result quotient.
REQ-008 SHALL provide port remainder  output  N  registered result remainder.
REQ-009 SHALL provide port busy  output  1  high in LOAD and ITER.
REQ-010 SHALL provide port done  output  1  one-cycle completion pulse, high in DONE.
REQ-011 SHALL provide port dz  output  1  divide-by-zero flag, valid while done is high and held until the next start is accepted.

Function
REQ-012 SHALL perform unsigned restoring division with registers A (N+1 bits), Q (N bits) and M (N bits), and iteration counter C (clog2(N+1) bits).
REQ-013 SHALL implement the FSM states IDLE, LOAD, ITER and DONE, and SHALL return to IDLE from any illegal state.
REQ-014 IDLE: SHALL go to LOAD on the rising edge where start=1, and SHALL otherwise remain in IDLE.
REQ-015 LOAD: SHALL set A=0, Q=dividend, M=divisor and C=N, then go to ITER.
REQ-016 ITER, one cycle per iteration: SHALL shift {A,Q} left by 1 and compute T = A_shifted - {0,M} in N+1 bits.
REQ-017 ITER: if T[N]=1, SHALL keep A_shifted and set Q[0]=0; otherwise SHALL set A=T and Q[0]=1.
REQ-018 ITER: SHALL decrement C each iteration, and SHALL go to DONE on the iteration where C reaches 0 (exactly N iterations).
REQ-019 DONE: SHALL load quotient=Q and remainder=A[N-1:0], drive done=1 for exactly one cycle, then go to IDLE.
REQ-020 SHALL assert done starting N+2 rising edges after the edge that samples start (start edge, LOAD edge, N ITER edges).
REQ-021 SHALL ignore start in LOAD, ITER and DONE; no queuing.
REQ-022 SHALL hold quotient, remainder and dz stable from DONE until the next DONE (or until reset).
REQ-023 SHALL accept a new start in the first IDLE cycle after DONE, giving a back-to-back period of N+3 cycles.
REQ-024 SHALL NOT change the running division when dividend or divisor change after LOAD.

Reset
REQ-025 rst_n=0 SHALL immediately force state=IDLE and clear A, Q, M, C, quotient, remainder, busy, done and dz to 0, without waiting for a clock edge.
REQ-026 Reset asserted mid-division SHALL abort the division with no done pulse; the first start after deassertion SHALL begin a fresh division.

Configuration
REQ-027 SHALL support macro DIVZERO_DETECT_EN.
REQ-028 With DIVZERO_DETECT_EN defined and divisor=0 in LOAD: SHALL skip ITER and go straight to DONE, with quotient={N{1}}, remainder=dividend, dz=1, and done 2 edges after start.
REQ-029 With DIVZERO_DETECT_EN defined and divisor!=0: SHALL behave as REQ-015..REQ-019 with dz=0.
REQ-030 Without DIVZERO_DETECT_EN: SHALL tie dz to 0 and run all N iterations on divisor=0, naturally yielding quotient={N{1}} and remainder=dividend after N+2 edges.

Verification
REQ-031 N=8, 100/7 -> quotient=14, remainder=2, done high exactly one cycle, N+2=10 edges after start.
REQ-032 N=8, 5/9 -> quotient=0, remainder=5; 255/1 -> quotient=255, remainder=0; back-to-back starts each complete in 11 cycles.
REQ-033 N=8, 200/0 -> with DIVZERO_DETECT_EN: quotient=255, remainder=200, dz=1, done 2 edges after start; without it: same quotient and remainder, dz=0, done after 10 edges.
REQ-034 Start 100/7, then pulse start with 50/5 and change the operand inputs during ITER -> result still 14 r 2 and only one done pulse.
REQ-035 Assert rst_n=0 at iteration 4 -> all outputs 0 immediately and no done; after release, a start with 9/3 -> quotient=3, remainder=0.
